be_uop_queue: RTL and testbench

- Backend-side receiver for the front-end uop stream. It sits downstream of the front-end uop-cache hook and upstream of rename/dispatch.
- It accepts ez90_pkg::ez90_uop_t beats on a valid/ready handshake and buffers them in a DEPTH-entry ring.
- It presents the oldest uop to dispatch on a second valid/ready handshake.
- Its in_ready does not depend on out_ready, which breaks the combinational ready path through the front end.
- Supports pipeline flush and exposes occupancy for front-end throttling.

---
 rtl/ez90_pkg.sv | 30 +++
 rtl/be_uop_queue.sv | 105 ++++++++++
 tb/tb_be_uop_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ez90_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ez90_pkg: shared uop type and backend uop-queue sizing constants.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ez90_pkg;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_LSU = 3'd2,
    FU_BR  = 3'd3,
    FU_FPU = 3'd4
  } ez90_fu_e;

  typedef struct packed {
    logic [7:0]  tag;
    ez90_fu_e    fu;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [19:0] imm;
  } ez90_uop_t;

  localparam int EZ90_UOPQ_DEPTH = 8;
  localparam int EZ90_UOPQ_AFULL = 6;

endpackage
`default_nettype wire

// File: rtl/be_uop_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | be_uop_queue: flushable uop ring between front end and dispatch.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module be_uop_queue
  import ez90_pkg::*;
#(
  parameter  int DEPTH        = EZ90_UOPQ_DEPTH,
  parameter  int AFULL_THRESH = EZ90_UOPQ_AFULL,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  ez90_uop_t     in_uop,
  output logic          in_ready,
  output logic          out_valid,
  output ez90_uop_t     out_uop,
  input  logic          out_ready,
  output logic [CW-1:0] occupancy,
  output logic          almost_full,
  output logic [CW-1:0] occ_hwm
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("be_uop_queue: DEPTH must be a power of two >= 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
      $error("be_uop_queue: AFULL_THRESH must be within 1..DEPTH");
    end
  endgenerate

  ez90_uop_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  // Ready looks only at registered state so out_ready never reaches in_ready.
  assign in_ready    = !rst && (count != DEPTH_C);
  assign out_valid   = (count != '0);
  assign out_uop     = mem[rd_ptr];
  assign occupancy   = count;
  assign almost_full = (count >= AFULL_C);

  assign push = in_valid & in_ready & !flush;
  assign pop  = out_valid & out_ready & !flush;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      occ_hwm <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
      if (count_next > occ_hwm) occ_hwm <= count_next;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_uop;
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == DEPTH_C)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count == '0)));
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= DEPTH_C);
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> $stable(out_uop));
`endif

endmodule
`default_nettype wire

// File: tb/tb_be_uop_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_be_uop_queue: random + directed bench with queue-based model.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_be_uop_queue;
  import ez90_pkg::*;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  ez90_uop_t     in_uop = '0;
  logic          in_ready;
  logic          out_valid;
  ez90_uop_t     out_uop;
  logic          out_ready = 1'b0;
  logic [CW-1:0] occupancy;
  logic          almost_full;
  logic [CW-1:0] occ_hwm;

  be_uop_queue #(.DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_uop(in_uop), .in_ready(in_ready),
    .out_valid(out_valid), .out_uop(out_uop), .out_ready(out_ready),
    .occupancy(occupancy), .almost_full(almost_full), .occ_hwm(occ_hwm)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: accepted uops in order, plus running peak occupancy.
  ez90_uop_t exp_q[$];
  int        exp_hwm = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ez90_uop_t mk_uop(input logic [7:0] tag);
    ez90_uop_t u;
    u.tag    = tag;
    u.fu     = ez90_fu_e'($urandom_range(0, 4));
    u.opcode = 7'($urandom);
    u.rd     = 5'($urandom);
    u.rs1    = 5'($urandom);
    u.rs2    = 5'($urandom);
    u.imm    = 20'($urandom);
    return u;
  endfunction

  // Monitor / scoreboard, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    int  sz;
    bit  do_push, do_pop;
    sz = exp_q.size();
    if (rst) begin
      chk("rst_in_ready",  64'(in_ready),  64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_occupancy", 64'(occupancy), 64'(0));
      exp_q.delete();
      exp_hwm = 0;
    end else begin
      chk("in_ready",    64'(in_ready),    64'(sz != DEPTH));
      chk("out_valid",   64'(out_valid),   64'(sz != 0));
      chk("occupancy",   64'(occupancy),   64'(sz));
      chk("almost_full", 64'(almost_full), 64'(sz >= AF));
      chk("occ_hwm",     64'(occ_hwm),     64'(exp_hwm));
      if (sz != 0 && out_valid)
        chk("out_uop", 64'(out_uop), 64'(exp_q[0]));
      do_pop  = (sz != 0) && out_ready && !flush;
      do_push = in_valid && (sz != DEPTH) && !flush;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(in_uop);
      end
      if (exp_q.size() > exp_hwm) exp_hwm = exp_q.size();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] tag, input bit rdy, input bit fl);
    in_valid  = v;
    in_uop    = mk_uop(tag);
    out_ready = rdy;
    flush     = fl;
    step();
  endtask

  logic [7:0] tag_ctr = 8'd0;

  initial begin
    // Reset, then idle.
    repeat (3) step();
    rst = 1'b0;
    repeat (10) drive(1'b0, 8'd0, 1'b0, 1'b0);

    // Fill 1..8 with dispatch stalled, then drain.
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    repeat (9) drive(1'b0, 8'd0, 1'b1, 1'b0);

    // Full plus pop: no push-through at full.
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    drive(1'b1, 8'h3F, 1'b1, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    repeat (8) drive(1'b0, 8'd0, 1'b1, 1'b0);

    // Async reset mid-operation with 4 queued.
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'(0));
    chk("async_occupancy", 64'(occupancy), 64'(0));
    chk("async_in_ready",  64'(in_ready),  64'(0));
    chk("async_occ_hwm",   64'(occ_hwm),   64'(0));
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);

    // Streaming with both sides always ready.
    for (int i = 0; i < 100; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);

    // Flush mid-stream with a concurrent beat, then tag 0xA.
    for (int i = 1; i <= 5; i++) drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    drive(1'b1, 8'h0A, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      tag_ctr++;
      drive(1'($urandom_range(0, 3) != 0), tag_ctr,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end
    repeat (DEPTH + 2) drive(1'b0, 8'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
